// File: rtl/obs_trace_pkg.sv
// Shared types for the observation-trace emitter.
//   obs_rec_t    : one packed observation record {seq, commit, mem_v, mem_wr, addr}
//   emit_state_e : emitter flow-control state
//   SEQ_W/ADDR_W : default field widths
package obs_trace_pkg;
   localparam int SEQ_W  = 8;
   localparam int ADDR_W = 32;
   localparam int REC_W  = SEQ_W + ADDR_W + 3;

   typedef struct packed {
      logic [SEQ_W-1:0]  seq;
      logic              commit;
      logic              mem_v;
      logic              mem_wr;
      logic [ADDR_W-1:0] addr;
   } obs_rec_t;

   typedef enum logic [1:0] {RUN, HOLD, ERR} emit_state_e;
endpackage

// File: rtl/obs_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter.
// The caller must never push while full unless it also pops in the same cycle.
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write din at the tail
//   pop, dout    : dout is the head entry (combinational); pop advances it
//   count        : occupancy, 0..DEPTH
//   full, empty  : occupancy flags
module obs_sync_fifo
   import obs_trace_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = logic [REC_W-1:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  T                       din,
   output T                       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   // Storage is not reset; count qualifies every entry.
   // At full with push+pop, wr_ptr==rd_ptr: the head is read this cycle and
   // the slot is rewritten at the edge, becoming the new tail.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/obs_trace_emitter.sv
// Observation-trace emitter: taps a core's commit and dmem request, tags
// each observation with a wrapping sequence number and streams it out
// through a FIFO over valid/ready. Requests a core stall near full and
// latches into ERR if a record is ever dropped.
//   clk, rst                       : clock, synchronous active-high reset
//   commit_valid, dmem_*           : tapped core events
//   core_stall                     : hold request to the core (HOLD or ERR)
//   out_valid/out_ready/out_data   : record stream {seq, commit, mem_v, mem_wr, addr}
//   overflow                       : sticky drop indication (state ERR)
//   count                          : FIFO occupancy
module obs_trace_emitter
   import obs_trace_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SEQW  = SEQ_W,
   parameter int AW    = ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   commit_valid,
   input  logic                   dmem_valid,
   input  logic [AW-1:0]          dmem_addr,
   input  logic                   dmem_wr,
   output logic                   core_stall,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SEQW+AW+2:0]     out_data,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] count
);
   localparam int RW = SEQW + AW + 3;
   localparam int CW = $clog2(DEPTH) + 1;
   // Stall one entry early so the cycle in flight while the core reacts still fits.
   localparam logic [CW-1:0] HI_MARK = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LO_MARK = CW'(DEPTH - 2);

   emit_state_e   state, state_nxt;
   logic [SEQW-1:0] seq;
   logic          push_req, push, pop, drop, full, empty;
   logic [RW-1:0] rec, head;
   logic [CW-1:0] count_nxt;

   assign push_req = (commit_valid | dmem_valid) && (state != ERR);
   assign pop      = out_valid & out_ready;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && !push;

   assign rec = {seq, commit_valid, dmem_valid, dmem_valid & dmem_wr,
                 dmem_valid ? dmem_addr : {AW{1'b0}}};

   obs_sync_fifo #(.DEPTH(DEPTH), .T(logic [RW-1:0])) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (rec),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign count_nxt  = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
   assign out_valid  = !empty && (state != ERR);
   assign out_data   = out_valid ? head : '0;
   assign core_stall = (state != RUN);
   assign overflow   = (state == ERR);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:  if (drop) state_nxt = ERR;
               else if (count_nxt >= HI_MARK) state_nxt = HOLD;
         HOLD: if (drop) state_nxt = ERR;
               else if (count_nxt <= LO_MARK) state_nxt = RUN;
         ERR:  state_nxt = ERR;
         default: state_nxt = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         seq   <= '0;
      end else begin
         state <= state_nxt;
         if (push) seq <= seq + 1'b1;
      end
   end
endmodule
